traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Two-road intersection phase sequencer driving NS (road 1) and EW (road 2) red/yellow/green lamps.
//  An internal prescaler makes a 1 s tick; the FSM orders phases and counts their durations in ticks.
//  Pedestrian requests can shorten the conflicting green. A countdown feeds the board 7-seg driver.
// PARAMETERS
//  TICK_DIV   125000000  clk cycles per tick (1 s at 125 MHz); legal >= 1
//  GREEN_S    8          green duration, ticks
//  YELLOW_S   2          yellow duration, ticks
//  ALLRED_S   1          all-red clearance, ticks
//  MIN_GREEN  3          minimum green before a ped request may cut it; 1..GREEN_S
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  ped_req    in   2  [0]=serve NS, [1]=serve EW; level or pulse, sampled every clk
//  ledr1/ledy1/ledg1  out 1 each  NS red/yellow/green lamps
//  ledr2/ledy2/ledg2  out 1 each  EW red/yellow/green lamps
//  ped_ack    out  2  1-clk pulse when the requested road's green starts
//  sec_left   out  8  ticks remaining in the current phase (dur - phase_cnt)
//  night      in   1  only with TRAFFIC_NIGHT_FLASH_EN; selects flashing mode
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst=0, async, also mid-phase): state=ALL_RED_A, phase_cnt=0, prescaler=0, pend=0.
//    Outputs at reset: ledr1=ledr2=1, all yellow/green=0, ped_ack=0, sec_left=ALLRED_S.
//  Prescaler counts 0..TICK_DIV-1. tick=1 for one clk when count==TICK_DIV-1, then wraps to 0.
//    With TICK_DIV=1, tick=1 every clk.
//  States and durations: ALL_RED_A(ALLRED_S) -> NS_GREEN(GREEN_S) -> NS_YELLOW(YELLOW_S)
//    -> ALL_RED_B(ALLRED_S) -> EW_GREEN(GREEN_S) -> EW_YELLOW(YELLOW_S) -> ALL_RED_A.
//  On each tick: if phase_cnt+1==dur, advance state and clear phase_cnt; else increment phase_cnt.
//    Nothing changes on non-tick cycles except the prescaler, pend and ped_ack.
//  Early cut: in NS_GREEN, a tick with pend[1]=1 and phase_cnt+1>=MIN_GREEN advances to NS_YELLOW.
//    Same rule in EW_GREEN with pend[0].
//  pend[i] is set by ped_req[i] in any clk, except while road i is green (request ignored there).
//    pend[i] clears on the clk the FSM enters road i's green; ped_ack[i] pulses on that same clk.
//    Simultaneous requests latch both pend bits, and each road is served in normal order.
//  Lamps decode combinationally from the registered state: exactly one lamp per road is on.
//    Lamps change on the clk after the tick.
//  sec_left is combinational from state and phase_cnt. Width rule: all durations < 256.
//  Illegal state encodings recover to ALL_RED_A on the next clk.
// CONFIGURATION
//  TRAFFIC_NIGHT_FLASH_EN defined: adds the night port and a FLASH state.
//    A tick with night=1 in any state enters FLASH: all red/green off, ledy1=ledy2 toggle each tick
//    (start at 1), sec_left=0, pend held, no acks.
//    A tick with night=0 in FLASH enters ALL_RED_A with phase_cnt=0.
//  TRAFFIC_NIGHT_FLASH_EN undefined: no night port, no FLASH state; 6-state cycle only.
// STRUCTURE
//  traffic_pkg: state enum (ALL_RED_A..EW_YELLOW, FLASH), the phase-duration lookup function,
//    and road index constants NS=0 and EW=1.
//  Sub-module tick_prescaler (param TICK_DIV; ports clk, rst, tick): reusable 1-s strobe.
//  Top contains the FSM, the phase counter, the pend/ack logic and the lamp decode.
// TESTING (bench uses TICK_DIV=4, defaults otherwise)
//  Reset release -> red-red for 4 clk, then NS green for 32 clk, NS yellow 8, all-red 4, EW green 32.
//  Full cycle with no requests -> period = 4*(2*1+2*8+2*2) = 88 clk; sec_left counts 8..1 in green.
//  ped_req[1] pulsed in the first NS_GREEN tick -> NS green lasts 3 ticks (12 clk);
//    ped_ack[1] pulses once, on EW_GREEN entry.
//  ped_req[0] held during NS_GREEN -> no pend, no ack, full 8-tick green.
//    ped_req[0]+[1] together in ALL_RED_A -> NS green is cut to 3 ticks; both acks fire in order.
//  rst low mid-EW_YELLOW (async, between clk edges) -> lamps red-red at once, sec_left=1, pend=0.
//  TRAFFIC_NIGHT_FLASH_EN: night=1 -> yellow lamps toggle every 4 clk with red/green off;
//    night=0 -> ALL_RED_A, then normal sequence.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encodings, road indices and phase helpers for the
// two-road traffic phase scheduler.
package traffic_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ALL_RED_A = 3'd0;
    localparam state_t NS_GREEN  = 3'd1;
    localparam state_t NS_YELLOW = 3'd2;
    localparam state_t ALL_RED_B = 3'd3;
    localparam state_t EW_GREEN  = 3'd4;
    localparam state_t EW_YELLOW = 3'd5;
    localparam state_t FLASH     = 3'd6;

    localparam int NS = 0;
    localparam int EW = 1;

    typedef enum logic {
        ROAD_NS = 1'b0,
        ROAD_EW = 1'b1
    } road_e;

    // FLASH and illegal encodings have no duration (countdown reads 0).
    function automatic logic [7:0] phase_dur(
        input state_t      s,
        input int unsigned green,
        input int unsigned yellow,
        input int unsigned allred
    );
        logic [7:0] d;
        case (s)
            ALL_RED_A: d = 8'(allred);
            NS_GREEN:  d = 8'(green);
            NS_YELLOW: d = 8'(yellow);
            ALL_RED_B: d = 8'(allred);
            EW_GREEN:  d = 8'(green);
            EW_YELLOW: d = 8'(yellow);
            default:   d = 8'd0;
        endcase
        return d;
    endfunction

    function automatic state_t next_phase(input state_t s);
        state_t n;
        case (s)
            ALL_RED_A: n = NS_GREEN;
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALL_RED_B;
            ALL_RED_B: n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            default:   n = ALL_RED_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clock strobe every TICK_DIV
// clocks; with TICK_DIV=1 the strobe is high on every clock.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 125000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road phase sequencer with pedestrian early-cut and countdown.
// Optional night flashing mode: define TRAFFIC_NIGHT_FLASH_EN.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 125000000,
    parameter int unsigned GREEN_S   = 8,
    parameter int unsigned YELLOW_S  = 2,
    parameter int unsigned ALLRED_S  = 1,
    parameter int unsigned MIN_GREEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic       ledr1,
    output logic       ledy1,
    output logic       ledg1,
    output logic       ledr2,
    output logic       ledy2,
    output logic       ledg2,
    output logic [1:0] ped_ack,
    output logic [7:0] sec_left
);

    logic       tick;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] ack_q, ack_d;
    logic [7:0] dur;
    logic [8:0] cnt_inc;
    logic       last;
    logic       cut;
    logic       legal;
    logic       in_flash;
    logic [1:0] green;
    logic [1:0] enter;
    logic [5:0] lamps;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic flash_q, flash_d;

    assign in_flash = (state_q == FLASH);
    assign legal    = (state_q <= EW_YELLOW) || in_flash;

    always_comb begin
        flash_d = flash_q;
        if (tick && night) begin
            flash_d = in_flash ? ~flash_q : 1'b1;
        end
    end
`else
    assign in_flash = 1'b0;
    assign legal    = (state_q <= EW_YELLOW);
`endif

    assign dur     = phase_dur(state_q, GREEN_S, YELLOW_S, ALLRED_S);
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign last    = (cnt_inc == {1'b0, dur});

    // A waiting request for the cross road may end green after MIN_GREEN.
    assign cut = (cnt_inc >= 9'(MIN_GREEN))
              && (((state_q == NS_GREEN) && pend_q[EW])
               || ((state_q == EW_GREEN) && pend_q[NS]));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!legal) begin
            state_d = ALL_RED_A;
            cnt_d   = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
            if (last || cut) begin
                state_d = next_phase(state_q);
                cnt_d   = '0;
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            if (night || in_flash) begin
                state_d = night ? FLASH : ALL_RED_A;
                cnt_d   = '0;
            end
`endif
        end
    end

    assign green[NS] = (state_q == NS_GREEN);
    assign green[EW] = (state_q == EW_GREEN);
    assign enter[NS] = (state_d == NS_GREEN) && !green[NS];
    assign enter[EW] = (state_d == EW_GREEN) && !green[EW];

    always_comb begin
        pend_d = pend_q;
        ack_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (enter[i]) begin
                pend_d[i] = 1'b0;
                ack_d[i]  = pend_q[i];
            end else if (ped_req[i] && !green[i] && !in_flash) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ALL_RED_A;
            cnt_q   <= '0;
            pend_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end

`ifdef TRAFFIC_NIGHT_FLASH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_q <= 1'b0;
        end else begin
            flash_q <= flash_d;
        end
    end
`endif

    // Lamp order: {r1, y1, g1, r2, y2, g2}.
    always_comb begin
        lamps = 6'b100_100;
        case (state_q)
            NS_GREEN:  lamps = 6'b001_100;
            NS_YELLOW: lamps = 6'b010_100;
            EW_GREEN:  lamps = 6'b100_001;
            EW_YELLOW: lamps = 6'b100_010;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH:     lamps = {1'b0, flash_q, 2'b00, flash_q, 1'b0};
`endif
            default:   lamps = 6'b100_100;
        endcase
    end

    assign {ledr1, ledy1, ledg1, ledr2, ledy2, ledg2} = lamps;
    assign ped_ack  = ack_q;
    assign sec_left = dur - cnt_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with TICK_DIV=4.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] ped_req;
    logic       night;
    logic       ledr1, ledy1, ledg1, ledr2, ledy2, ledg2;
    logic [1:0] ped_ack;
    logic [7:0] sec_left;

    int total;
    int bad;
    int ack0_n;
    int ack1_n;

    typedef struct {
        int         steps;
        logic [1:0] req;
        logic [5:0] lamps;
        logic [7:0] sec;
        logic [1:0] ack;
    } vec_t;

    vec_t vt[18];

    traffic_phase_scheduler #(
        .TICK_DIV (4),
        .GREEN_S  (8),
        .YELLOW_S (2),
        .ALLRED_S (1),
        .MIN_GREEN(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ped_req (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        .night   (night),
`endif
        .ledr1   (ledr1),
        .ledy1   (ledy1),
        .ledg1   (ledg1),
        .ledr2   (ledr2),
        .ledy2   (ledy2),
        .ledg2   (ledg2),
        .ped_ack (ped_ack),
        .sec_left(sec_left)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] lamps();
        return {ledr1, ledy1, ledg1, ledr2, ledy2, ledg2};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ack0_n += int'(ped_ack[0]);
            ack1_n += int'(ped_ack[1]);
        end
    endtask

    task automatic check_out(input string nm, input logic [5:0] l,
                             input logic [7:0] s, input logic [1:0] a);
        chk({nm, ".lamps"}, 16'(lamps()), 16'(l));
        chk({nm, ".sec"}, 16'(sec_left), 16'(s));
        chk({nm, ".ack"}, 16'(ped_ack), 16'(a));
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        ped_req = 2'b00;
        repeat (3) @(negedge clk);
        check_out("in_reset", 6'b100100, 8'd1, 2'b00);
        rst    = 1'b1;
        ack0_n = 0;
        ack1_n = 0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        ack0_n  = 0;
        ack1_n  = 0;
        rst     = 1'b0;
        ped_req = 2'b00;
        night   = 1'b0;

        vt[0]  = '{0,  2'b00, 6'b100100, 8'd1, 2'b00};
        vt[1]  = '{3,  2'b00, 6'b100100, 8'd1, 2'b00};
        vt[2]  = '{1,  2'b00, 6'b001100, 8'd8, 2'b00};
        vt[3]  = '{4,  2'b00, 6'b001100, 8'd7, 2'b00};
        vt[4]  = '{27, 2'b00, 6'b001100, 8'd1, 2'b00};
        vt[5]  = '{1,  2'b00, 6'b010100, 8'd2, 2'b00};
        vt[6]  = '{4,  2'b00, 6'b010100, 8'd1, 2'b00};
        vt[7]  = '{4,  2'b00, 6'b100100, 8'd1, 2'b00};
        vt[8]  = '{4,  2'b00, 6'b100001, 8'd8, 2'b00};
        vt[9]  = '{31, 2'b00, 6'b100001, 8'd1, 2'b00};
        vt[10] = '{1,  2'b00, 6'b100010, 8'd2, 2'b00};
        vt[11] = '{8,  2'b00, 6'b100100, 8'd1, 2'b00};
        vt[12] = '{4,  2'b00, 6'b001100, 8'd8, 2'b00};
        vt[13] = '{31, 2'b01, 6'b001100, 8'd1, 2'b00};
        vt[14] = '{1,  2'b00, 6'b010100, 8'd2, 2'b00};
        vt[15] = '{12, 2'b00, 6'b100001, 8'd8, 2'b00};
        vt[16] = '{31, 2'b00, 6'b100001, 8'd1, 2'b00};
        vt[17] = '{1,  2'b00, 6'b100010, 8'd2, 2'b00};

        // Full no-request cycle, then ped_req[0] held through NS green.
        do_reset();
        for (int v = 0; v < 18; v++) begin
            ped_req = vt[v].req;
            step(vt[v].steps);
            check_out($sformatf("vec%0d", v), vt[v].lamps,
                      vt[v].sec, vt[v].ack);
        end
        chk("vec.ack0_count", 16'(ack0_n), 16'd0);
        chk("vec.ack1_count", 16'(ack1_n), 16'd0);

        // EW request pulsed in the first NS green cycle cuts NS green.
        do_reset();
        step(4);
        ped_req = 2'b10;
        step(1);
        ped_req = 2'b00;
        step(10);
        check_out("cut.k15", 6'b001100, 8'd6, 2'b00);
        step(1);
        check_out("cut.k16", 6'b010100, 8'd2, 2'b00);
        step(12);
        check_out("cut.k28", 6'b100001, 8'd8, 2'b10);
        step(1);
        check_out("cut.k29", 6'b100001, 8'd8, 2'b00);
        step(30);
        check_out("cut.k59", 6'b100001, 8'd1, 2'b00);
        step(1);
        check_out("cut.k60", 6'b100010, 8'd2, 2'b00);
        chk("cut.ack0_count", 16'(ack0_n), 16'd0);
        chk("cut.ack1_count", 16'(ack1_n), 16'd1);

        // Both requests during ALL_RED_A.
        do_reset();
        ped_req = 2'b11;
        step(1);
        ped_req = 2'b00;
        step(3);
        check_out("both.k4", 6'b001100, 8'd8, 2'b01);
        step(11);
        check_out("both.k15", 6'b001100, 8'd6, 2'b00);
        step(1);
        check_out("both.k16", 6'b010100, 8'd2, 2'b00);
        step(12);
        check_out("both.k28", 6'b100001, 8'd8, 2'b10);
        step(31);
        check_out("both.k59", 6'b100001, 8'd1, 2'b00);
        chk("both.ack0_count", 16'(ack0_n), 16'd1);
        chk("both.ack1_count", 16'(ack1_n), 16'd1);

        // Async reset mid EW yellow with an EW request pending.
        do_reset();
        step(81);
        check_out("arst.k81", 6'b100010, 8'd2, 2'b00);
        ped_req = 2'b10;
        step(1);
        ped_req = 2'b00;
        #2 rst = 1'b0;
        #1 check_out("arst.now", 6'b100100, 8'd1, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        step(4);
        check_out("arst.k4", 6'b001100, 8'd8, 2'b00);
        step(16);
        check_out("arst.k20", 6'b001100, 8'd4, 2'b00);
        step(15);
        check_out("arst.k35", 6'b001100, 8'd1, 2'b00);
        step(1);
        check_out("arst.k36", 6'b010100, 8'd2, 2'b00);

`ifdef TRAFFIC_NIGHT_FLASH_EN
        night = 1'b1;
        step(4);
        check_out("night.on", 6'b010010, 8'd0, 2'b00);
        step(4);
        check_out("night.tog", 6'b000000, 8'd0, 2'b00);
        step(4);
        check_out("night.tog2", 6'b010010, 8'd0, 2'b00);
        night = 1'b0;
        step(4);
        check_out("night.off", 6'b100100, 8'd1, 2'b00);
        step(4);
        check_out("night.ns", 6'b001100, 8'd8, 2'b00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
